// File: rtl/commit_chk_pkg.sv
// commit_chk_pkg: record kinds, error codes, checker states and the expected-record layout.
// COMMIT_CHECK_DATA_EN adds register/memory data and address fields to each record.
package commit_chk_pkg;

    typedef enum logic [2:0] {
        K_NOP  = 3'd0,
        K_REG  = 3'd1,
        K_LD   = 3'd2,
        K_ST   = 3'd3,
        K_STU  = 3'd4,
        K_HALT = 3'd5
    } kind_t;

    typedef enum logic [2:0] {
        E_NONE      = 3'd0,
        E_UNDERFLOW = 3'd1,
        E_KIND      = 3'd2,
        E_PC        = 3'd3,
        E_REG       = 3'd4,
        E_DATA      = 3'd5,
        E_ADDR      = 3'd6
    } err_t;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    typedef struct packed {
        kind_t       kind;
        logic [15:0] pc;
        logic [2:0]  rd;
`ifdef COMMIT_CHECK_DATA_EN
        logic [15:0] regval;
        logic [15:0] addr;
        logic [15:0] memval;
`endif
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    function automatic kind_t commit_kind(input logic regwrite, input logic memread,
                                          input logic memwrite, input logic halt);
        return (regwrite && memwrite) ? K_STU  :
               (regwrite && memread)  ? K_LD   :
               regwrite               ? K_REG  :
               halt                   ? K_HALT :
               memwrite               ? K_ST   : K_NOP;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: synchronous FIFO of expected commit records with full/empty flags.
module commit_fifo
    import commit_chk_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W = REC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/commit_checker.sv
// commit_checker: compares each retired instruction against a queue of expected commit records.
// COMMIT_CHECK_DATA_EN also compares register/memory data and memory address.
module commit_checker
    import commit_chk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [2:0]  exp_kind,
    input  logic [15:0] exp_pc,
    input  logic [2:0]  exp_reg,
    input  logic [15:0] exp_regval,
    input  logic [15:0] exp_addr,
    input  logic [15:0] exp_memval,
    input  logic        c_valid,
    input  logic [15:0] c_pc,
    input  logic        c_regwrite,
    input  logic [2:0]  c_wreg,
    input  logic [15:0] c_wdata,
    input  logic        c_memread,
    input  logic        c_memwrite,
    input  logic [15:0] c_memaddr,
    input  logic [15:0] c_memdata,
    input  logic        c_halt,
    output logic [15:0] inst_count,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [15:0] err_inum
);

    state_t      state;
    state_t      next;
    err_t        cmp_err;
    err_t        err_q;
    rec_t        in_rec;
    rec_t        head;
    kind_t       ckind;
    logic [REC_W-1:0] head_bits;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        retire;
    logic        uses_reg;

    assign in_rec.kind = kind_t'(exp_kind);
    assign in_rec.pc   = exp_pc;
    assign in_rec.rd   = exp_reg;
`ifdef COMMIT_CHECK_DATA_EN
    assign in_rec.regval = exp_regval;
    assign in_rec.addr   = exp_addr;
    assign in_rec.memval = exp_memval;
`else
    logic unused_data;
    assign unused_data = ^{exp_regval, exp_addr, exp_memval, c_wdata, c_memaddr, c_memdata};
`endif

    assign head     = rec_t'(head_bits);
    assign ckind    = commit_kind(c_regwrite, c_memread, c_memwrite, c_halt);
    assign retire   = state == S_RUN && c_valid;
    assign push     = exp_valid && exp_ready;
    assign pop      = retire && !empty;
    assign uses_reg = head.kind inside {K_REG, K_LD, K_STU};

    commit_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_rec),
        .dout  (head_bits),
        .full  (full),
        .empty (empty)
    );

    // First failing field wins; kind is checked before any kind-dependent field.
    always_comb begin
        cmp_err = E_NONE;
        if (head.kind != ckind) cmp_err = E_KIND;
        else if (head.pc != c_pc) cmp_err = E_PC;
        else if (uses_reg && head.rd != c_wreg) cmp_err = E_REG;
`ifdef COMMIT_CHECK_DATA_EN
        else if ((uses_reg && head.regval != c_wdata) ||
                 (head.kind inside {K_ST, K_STU} && head.memval != c_memdata)) cmp_err = E_DATA;
        else if (head.kind inside {K_LD, K_ST, K_STU} && head.addr != c_memaddr) cmp_err = E_ADDR;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else state <= next;
    end

    always_comb begin
        next = state;
        if (retire) next = (empty || cmp_err != E_NONE) ? S_ERROR :
                           (ckind == K_HALT) ? S_HALTED : S_RUN;
    end

    always_comb begin
        exp_ready = !rst && state == S_RUN && !full;
        done      = state == S_HALTED;
        error     = state == S_ERROR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_count <= '0;
            err_q      <= E_NONE;
            err_inum   <= '0;
        end else if (retire) begin
            if (empty || cmp_err != E_NONE) begin
                err_q    <= empty ? E_UNDERFLOW : cmp_err;
                err_inum <= inst_count;
            end else if (inst_count != 16'hFFFF) begin
                inst_count <= inst_count + 16'd1;
            end
        end
    end

    assign err_code = err_q;

endmodule

// File: tb/tb_commit_checker.sv
// tb_commit_checker: directed scenarios for commit_checker, one task per feature.
module tb_commit_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exp_valid = 1'b0;
    logic        exp_ready;
    logic [2:0]  exp_kind = '0;
    logic [15:0] exp_pc = '0;
    logic [2:0]  exp_reg = '0;
    logic [15:0] exp_regval = '0;
    logic [15:0] exp_addr = '0;
    logic [15:0] exp_memval = '0;
    logic        c_valid = 1'b0;
    logic [15:0] c_pc = '0;
    logic        c_regwrite = 1'b0;
    logic [2:0]  c_wreg = '0;
    logic [15:0] c_wdata = '0;
    logic        c_memread = 1'b0;
    logic        c_memwrite = 1'b0;
    logic [15:0] c_memaddr = '0;
    logic [15:0] c_memdata = '0;
    logic        c_halt = 1'b0;
    logic [15:0] inst_count;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [15:0] err_inum;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    commit_checker #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_kind(exp_kind), .exp_pc(exp_pc), .exp_reg(exp_reg),
        .exp_regval(exp_regval), .exp_addr(exp_addr), .exp_memval(exp_memval),
        .c_valid(c_valid), .c_pc(c_pc), .c_regwrite(c_regwrite), .c_wreg(c_wreg),
        .c_wdata(c_wdata), .c_memread(c_memread), .c_memwrite(c_memwrite),
        .c_memaddr(c_memaddr), .c_memdata(c_memdata), .c_halt(c_halt),
        .inst_count(inst_count), .done(done), .error(error),
        .err_code(err_code), .err_inum(err_inum)
    );

    task automatic apply_reset;
        rst = 1'b1;
        exp_valid = 1'b0;
        c_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic set_exp(input logic [2:0] k, input logic [15:0] pc, input logic [2:0] rd,
                           input logic [15:0] rv, input logic [15:0] ad, input logic [15:0] mv);
        exp_kind = k; exp_pc = pc; exp_reg = rd;
        exp_regval = rv; exp_addr = ad; exp_memval = mv;
    endtask

    task automatic set_commit(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                              input logic [15:0] wd, input logic mr, input logic mw,
                              input logic [15:0] ma, input logic [15:0] md, input logic h);
        c_pc = pc; c_regwrite = rw; c_wreg = wr; c_wdata = wd;
        c_memread = mr; c_memwrite = mw; c_memaddr = ma; c_memdata = md; c_halt = h;
    endtask

    task automatic push(input logic [2:0] k, input logic [15:0] pc, input logic [2:0] rd,
                        input logic [15:0] rv, input logic [15:0] ad, input logic [15:0] mv);
        set_exp(k, pc, rd, rv, ad, mv);
        exp_valid = 1'b1;
        @(posedge clk); #1;
        exp_valid = 1'b0;
    endtask

    task automatic commit(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                          input logic [15:0] wd, input logic mr, input logic mw,
                          input logic [15:0] ma, input logic [15:0] md, input logic h);
        set_commit(pc, rw, wr, wd, mr, mw, ma, md, h);
        c_valid = 1'b1;
        @(posedge clk); #1;
        c_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (exp_ready !== 1'b0) $display("FAIL reset_ready_in_rst got=%0b exp=0", exp_ready); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (exp_ready !== 1'b1) $display("FAIL reset_ready_after got=%0b exp=1", exp_ready); else passes++;
        checks++; if ({inst_count, done, error, err_code, err_inum} !== 37'd0)
            $display("FAIL reset_outputs got=%h/%b/%b/%0d/%h exp=all zero", inst_count, done, error, err_code, err_inum);
        else passes++;
    endtask

    task automatic test_match_halt;
        apply_reset();
        push(3'd1, 16'd0, 3'd1, 16'd5, 16'd0, 16'd0);
        push(3'd5, 16'd2, 3'd0, 16'd0, 16'd0, 16'd0);
        commit(16'd0, 1'b1, 3'd1, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if (done !== 1'b0) $display("FAIL halt_done_early got=%0b exp=0", done); else passes++;
        commit(16'd2, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        checks++; if (inst_count !== 16'd2) $display("FAIL halt_count got=%0d exp=2", inst_count); else passes++;
        checks++; if (done !== 1'b1) $display("FAIL halt_done got=%0b exp=1", done); else passes++;
        checks++; if (error !== 1'b0) $display("FAIL halt_error got=%0b exp=0", error); else passes++;
        checks++; if (exp_ready !== 1'b0) $display("FAIL halt_ready got=%0b exp=0", exp_ready); else passes++;
        commit(16'd9, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if ({inst_count, error, done} !== {16'd2, 1'b0, 1'b1})
            $display("FAIL halt_sticky got=%0d/%b/%b exp=2/0/1", inst_count, error, done);
        else passes++;
    endtask

    task automatic test_data_mismatch;
        apply_reset();
        push(3'd1, 16'd0, 3'd1, 16'd5, 16'd0, 16'd0);
        commit(16'd0, 1'b1, 3'd1, 16'd6, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
`ifdef COMMIT_CHECK_DATA_EN
        checks++; if ({error, err_code, err_inum} !== {1'b1, 3'd5, 16'd0})
            $display("FAIL data_err got=%b/%0d/%0d exp=1/5/0", error, err_code, err_inum);
        else passes++;
`else
        checks++; if ({error, err_code, inst_count} !== {1'b0, 3'd0, 16'd1})
            $display("FAIL data_ignored got=%b/%0d/%0d exp=0/0/1", error, err_code, inst_count);
        else passes++;
`endif
        apply_reset();
        push(3'd3, 16'd4, 3'd0, 16'd0, 16'd10, 16'd4);
        commit(16'd4, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 16'd11, 16'd4, 1'b0);
`ifdef COMMIT_CHECK_DATA_EN
        checks++; if ({error, err_code} !== {1'b1, 3'd6})
            $display("FAIL addr_err got=%b/%0d exp=1/6", error, err_code);
        else passes++;
`else
        checks++; if ({error, err_code} !== {1'b0, 3'd0})
            $display("FAIL addr_ignored got=%b/%0d exp=0/0", error, err_code);
        else passes++;
`endif
    endtask

    task automatic test_field_errors;
        apply_reset();
        push(3'd2, 16'd0, 3'd3, 16'd7, 16'd10, 16'd0);
        push(3'd0, 16'd1, 3'd0, 16'd0, 16'd0, 16'd0);
        commit(16'd0, 1'b1, 3'd3, 16'd7, 1'b1, 1'b0, 16'd10, 16'd0, 1'b0);
        checks++; if ({inst_count, error} !== {16'd1, 1'b0})
            $display("FAIL ld_match got=%0d/%b exp=1/0", inst_count, error);
        else passes++;
        commit(16'd9, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if ({error, err_code, err_inum, inst_count} !== {1'b1, 3'd3, 16'd1, 16'd1})
            $display("FAIL pc_err got=%b/%0d/%0d/%0d exp=1/3/1/1", error, err_code, err_inum, inst_count);
        else passes++;
        apply_reset();
        push(3'd1, 16'd0, 3'd1, 16'd5, 16'd0, 16'd0);
        commit(16'd0, 1'b1, 3'd2, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if ({error, err_code} !== {1'b1, 3'd4})
            $display("FAIL reg_err got=%b/%0d exp=1/4", error, err_code);
        else passes++;
    endtask

    task automatic test_underflow;
        apply_reset();
        set_exp(3'd5, 16'd0, 3'd0, 16'd0, 16'd0, 16'd0);
        set_commit(16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        exp_valid = 1'b1;
        c_valid = 1'b1;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        c_valid = 1'b0;
        checks++; if ({error, err_code, done} !== {1'b1, 3'd1, 1'b0})
            $display("FAIL underflow got=%b/%0d/%b exp=1/1/0", error, err_code, done);
        else passes++;
    endtask

    task automatic test_full;
        apply_reset();
        for (int i = 0; i < 8; i++) push(3'd0, 16'(i), 3'd0, 16'd0, 16'd0, 16'd0);
        checks++; if (exp_ready !== 1'b0) $display("FAIL full_ready got=%0b exp=0", exp_ready); else passes++;
        push(3'd0, 16'd8, 3'd0, 16'd0, 16'd0, 16'd0);
        checks++; if (exp_ready !== 1'b0) $display("FAIL full_hold got=%0b exp=0", exp_ready); else passes++;
        commit(16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if ({exp_ready, inst_count} !== {1'b1, 16'd1})
            $display("FAIL full_release got=%b/%0d exp=1/1", exp_ready, inst_count);
        else passes++;
        for (int i = 1; i < 8; i++) commit(16'(i), 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if ({inst_count, error} !== {16'd8, 1'b0})
            $display("FAIL full_drain got=%0d/%b exp=8/0", inst_count, error);
        else passes++;
        commit(16'd8, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if ({error, err_code, err_inum} !== {1'b1, 3'd1, 16'd8})
            $display("FAIL full_ninth_dropped got=%b/%0d/%0d exp=1/1/8", error, err_code, err_inum);
        else passes++;
    endtask

    task automatic test_back_to_back;
        apply_reset();
        push(3'd1, 16'd0, 3'd1, 16'd5, 16'd0, 16'd0);
        set_exp(3'd1, 16'd1, 3'd2, 16'd6, 16'd0, 16'd0);
        set_commit(16'd0, 1'b1, 3'd1, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        exp_valid = 1'b1;
        c_valid = 1'b1;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        c_valid = 1'b0;
        commit(16'd1, 1'b1, 3'd2, 16'd6, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if ({inst_count, error} !== {16'd2, 1'b0})
            $display("FAIL b2b got=%0d/%b exp=2/0", inst_count, error);
        else passes++;
    endtask

    task automatic test_kind_and_midreset;
        apply_reset();
        push(3'd3, 16'd0, 3'd0, 16'd0, 16'd20, 16'd3);
        for (int i = 1; i < 4; i++) push(3'd1, 16'(i), 3'd1, 16'd1, 16'd0, 16'd0);
        commit(16'd0, 1'b1, 3'd0, 16'd0, 1'b0, 1'b1, 16'd20, 16'd3, 1'b0);
        checks++; if ({error, err_code, exp_ready} !== {1'b1, 3'd2, 1'b0})
            $display("FAIL kind_err got=%b/%0d/%b exp=1/2/0", error, err_code, exp_ready);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if ({inst_count, done, error, err_code, err_inum, exp_ready} !== 38'd0)
            $display("FAIL midreset_async got=%0d/%b/%b/%0d/%0d/%b exp=all zero",
                     inst_count, done, error, err_code, err_inum, exp_ready);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (exp_ready !== 1'b1) $display("FAIL midreset_ready got=%0b exp=1", exp_ready); else passes++;
        commit(16'd1, 1'b1, 3'd1, 16'd1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        checks++; if ({error, err_code} !== {1'b1, 3'd1})
            $display("FAIL midreset_empty got=%b/%0d exp=1/1", error, err_code);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_match_halt();
        test_data_mismatch();
        test_field_errors();
        test_underflow();
        test_full();
        test_back_to_back();
        test_kind_and_midreset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
